grid_clb_flex: RTL and testbench



---
 rtl/grid_clb_flex.sv | 120 ++++++++++++
 tb/tb_grid_clb_flex.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/grid_clb_flex.sv
// Configurable logic block tile: NUM_BLE LUT+FF elements behind an input crossbar, programmed
// through a serial config chain. Optional macro CLB_FEEDBACK_EN adds BLE outputs as crossbar sources.
module grid_clb_flex #(
  parameter int NUM_IN  = 40,
  parameter int NUM_BLE = 10,
  parameter int LUT_K   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ccff_en,
  input  logic               ccff_head,
  input  logic               cfg_done,
  input  logic [NUM_IN-1:0]  clb_I,
  output logic [NUM_BLE-1:0] clb_O,
  output logic               ccff_tail,
  output logic               cfg_active,
  output logic               cfg_err,
  output logic [1:0]         cfg_state
);

`ifdef CLB_FEEDBACK_EN
  localparam int NSRC = NUM_IN + NUM_BLE;
`else
  localparam int NSRC = NUM_IN;
`endif
  localparam int SELW     = $clog2(NSRC);
  localparam int TT       = 2 ** LUT_K;
  localparam int BLE_BITS = TT + LUT_K * SELW + 1;
  localparam int CFG_BITS = NUM_BLE * BLE_BITS;
  localparam int CNTW     = $clog2(CFG_BITS + 2);
  localparam int SRCW     = 2 ** SELW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_RUN   = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t              state;
  logic [CFG_BITS-1:0] cfg;
  logic [CNTW-1:0]     cnt;
  logic [CNTW-1:0]     cnt_inc;
  logic [NUM_BLE-1:0]  flop;
  logic [NUM_BLE-1:0]  ble_lut;
  logic [NUM_BLE-1:0]  regsel;
  logic [SRCW-1:0]     src_pad;
  logic                run;

  assign run        = (state == S_RUN);
  assign cfg_active = run;
  assign cfg_err    = (state == S_ERR);
  assign cfg_state  = state;
  assign ccff_tail  = cfg[CFG_BITS-1];

  // Bit counter saturates one past a full load so over-length loads stay distinguishable.
  assign cnt_inc = (cnt == CNTW'(CFG_BITS + 1)) ? cnt : cnt + 1'b1;

  // Padding above NSRC reads as 0, so out-of-range selects give a constant 0 input.
  always_comb begin
    src_pad = '0;
`ifdef CLB_FEEDBACK_EN
    src_pad[NSRC-1:0] = {clb_O, clb_I};
`else
    src_pad[NSRC-1:0] = clb_I;
`endif
  end

  for (genvar b = 0; b < NUM_BLE; b++) begin : g_ble
    localparam int BASE = b * BLE_BITS;
    logic [TT-1:0]    truth;
    logic [LUT_K-1:0] lut_in;

    assign truth = cfg[BASE +: TT];
    for (genvar k = 0; k < LUT_K; k++) begin : g_in
      logic [SELW-1:0] sel;
      assign sel       = cfg[BASE + TT + k * SELW +: SELW];
      assign lut_in[k] = src_pad[sel];
    end
    assign ble_lut[b] = truth[lut_in];
    assign regsel[b]  = cfg[BASE + BLE_BITS - 1];
  end

  assign clb_O = ((regsel & flop) | (~regsel & ble_lut)) & {NUM_BLE{run}};

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg   <= '0;
      cnt   <= '0;
      flop  <= '0;
      state <= S_IDLE;
    end else begin
      if (ccff_en) cfg <= {cfg[CFG_BITS-2:0], ccff_head};
      flop <= run ? ble_lut : '0;
      case (state)
        S_IDLE: begin
          if (ccff_en) begin
            state <= S_SHIFT;
            cnt   <= CNTW'(1);
          end
        end
        S_SHIFT: begin
          if (ccff_en) cnt <= cnt_inc;
          else if (cfg_done) state <= (cnt == CNTW'(CFG_BITS)) ? S_RUN : S_ERR;
        end
        S_RUN: begin
          if (ccff_en) begin
            state <= S_SHIFT;
            cnt   <= CNTW'(1);
          end
        end
        S_ERR: begin
          if (ccff_en) cnt <= cnt_inc;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_clb_flex.sv
// Directed bench for grid_clb_flex: reset, load/run, registered BLE, length errors,
// chain tail timing and reset during shift.
module tb_grid_clb_flex;
  localparam int NUM_IN  = 40;
  localparam int NUM_BLE = 10;
  localparam int LUT_K   = 4;
`ifdef CLB_FEEDBACK_EN
  localparam int NSRC = NUM_IN + NUM_BLE;
`else
  localparam int NSRC = NUM_IN;
`endif
  localparam int SELW     = $clog2(NSRC);
  localparam int TT       = 2 ** LUT_K;
  localparam int BLE_BITS = TT + LUT_K * SELW + 1;
  localparam int CFG_BITS = NUM_BLE * BLE_BITS;

  logic               clk = 1'b0;
  logic               reset;
  logic               ccff_en;
  logic               ccff_head;
  logic               cfg_done;
  logic [NUM_IN-1:0]  clb_I;
  logic [NUM_BLE-1:0] clb_O;
  logic               ccff_tail;
  logic               cfg_active;
  logic               cfg_err;
  logic [1:0]         cfg_state;

  logic [CFG_BITS-1:0] img;
  int n_checks = 0;
  int n_errors = 0;

  grid_clb_flex #(.NUM_IN(NUM_IN), .NUM_BLE(NUM_BLE), .LUT_K(LUT_K)) dut (
    .clk(clk), .reset(reset), .ccff_en(ccff_en), .ccff_head(ccff_head),
    .cfg_done(cfg_done), .clb_I(clb_I), .clb_O(clb_O), .ccff_tail(ccff_tail),
    .cfg_active(cfg_active), .cfg_err(cfg_err), .cfg_state(cfg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic do_reset();
    reset = 1'b1; ccff_en = 1'b0; cfg_done = 1'b0; ccff_head = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic shift_bit(input logic b, input logic done);
    ccff_en = 1'b1; ccff_head = b; cfg_done = done;
    @(posedge clk); #1;
    ccff_en = 1'b0; cfg_done = 1'b0;
  endtask

  task automatic idle_cycle(input logic done);
    ccff_en = 1'b0; cfg_done = done;
    @(posedge clk); #1;
    cfg_done = 1'b0;
  endtask

  // Shifts n bits of img, first bit = img[CFG_BITS-1]; bits past the image are 0.
  task automatic load_img(input int n);
    for (int i = 0; i < n; i++)
      shift_bit((i < CFG_BITS) ? img[CFG_BITS-1-i] : 1'b0, 1'b0);
  endtask

  task automatic put_ble(input int b, input logic [TT-1:0] truth,
                         input int s0, input int s1, input int s2, input int s3,
                         input logic rs);
    int base;
    int sels[4];
    base = b * BLE_BITS;
    sels[0] = s0; sels[1] = s1; sels[2] = s2; sels[3] = s3;
    for (int t = 0; t < TT; t++) img[base + t] = truth[t];
    for (int k = 0; k < LUT_K; k++)
      for (int w = 0; w < SELW; w++)
        img[base + TT + k * SELW + w] = sels[k][w];
    img[base + BLE_BITS - 1] = rs;
  endtask

  initial begin
    logic tail_seen;
    reset = 1'b1; ccff_en = 1'b0; ccff_head = 1'b0; cfg_done = 1'b0; clb_I = '0;

    // Reset held with random inputs
    for (int c = 0; c < 4; c++) begin
      clb_I = NUM_IN'({$urandom(), $urandom()});
      ccff_en = 1'($urandom_range(0, 1));
      ccff_head = 1'($urandom_range(0, 1));
      cfg_done = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    chk("rst_clb_O", clb_O, '0);
    chk("rst_tail", ccff_tail, 1'b0);
    chk("rst_active", cfg_active, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_state", cfg_state, 2'd0);
    reset = 1'b0; ccff_en = 1'b0; cfg_done = 1'b0;
    idle_cycle(1'b1);
    chk("idle_done_active", cfg_active, 1'b0);
    chk("idle_done_state", cfg_state, 2'd0);

    // Image: BLE0 = AND(I0..I3) comb; BLE1 = XOR(I0,I1) registered, unused inputs select out of range.
    img = '0;
    put_ble(0, 16'h8000, 0, 1, 2, 3, 1'b0);
    put_ble(1, 16'h0006, 0, 1, 63, 63, 1'b1);

    load_img(CFG_BITS);
    chk("load_state_shift", cfg_state, 2'd1);
    clb_I = '0;
    clb_I[3:0] = 4'hF;
    #1;
    chk("pre_run_active", cfg_active, 1'b0);
    chk("pre_run_clb_O", clb_O, '0);
    idle_cycle(1'b1);
    chk("run_active", cfg_active, 1'b1);
    chk("run_err", cfg_err, 1'b0);
    chk("and_F", clb_O, 10'h001);
    clb_I[3:0] = 4'hE; #1;
    chk("and_E_first_reg0", clb_O, 10'h000);
    @(posedge clk); #1;
    chk("xor_reg_late", clb_O, 10'h002);
    clb_I[3:0] = 4'h3; #1;
    chk("xor_reg_hold", clb_O, 10'h002);
    @(posedge clk); #1;
    chk("xor_reg_zero", clb_O, 10'h000);
    clb_I[3:0] = 4'hF;
    idle_cycle(1'b1);
    chk("run_done_ignored", cfg_active, 1'b1);
    chk("run_and_again", clb_O, 10'h001);
    shift_bit(1'b0, 1'b0);
    chk("reshift_state", cfg_state, 2'd1);
    chk("reshift_clb_O", clb_O, '0);
    chk("reshift_active", cfg_active, 1'b0);

    // Short load -> ERR, sticky until reset
    do_reset();
    load_img(CFG_BITS - 1);
    idle_cycle(1'b1);
    chk("short_err", cfg_err, 1'b1);
    chk("short_active", cfg_active, 1'b0);
    chk("short_state", cfg_state, 2'd3);
    clb_I = '1;
    idle_cycle(1'b1);
    shift_bit(1'b1, 1'b1);
    chk("err_sticky", cfg_err, 1'b1);
    chk("err_clb_O", clb_O, '0);
    do_reset();
    chk("err_cleared", cfg_err, 1'b0);
    load_img(CFG_BITS + 1);
    idle_cycle(1'b1);
    chk("long_err", cfg_err, 1'b1);

    // Alternating 1,0 pattern: first bit reaches the tail on shift CFG_BITS
    do_reset();
    for (int n = 1; n <= CFG_BITS + 2; n++) begin
      shift_bit(1'(n % 2), 1'b0);
      if (n == CFG_BITS - 1) chk("tail_n409", ccff_tail, 1'b0);
      if (n == CFG_BITS)     chk("tail_n410", ccff_tail, 1'b1);
      if (n == CFG_BITS + 1) chk("tail_n411", ccff_tail, 1'b0);
      if (n == CFG_BITS + 2) chk("tail_n412", ccff_tail, 1'b1);
    end

    // Reset after 200 shifts overrides shift and done; reload works normally
    do_reset();
    for (int n = 0; n < 200; n++) shift_bit(1'b1, 1'b0);
    reset = 1'b1; ccff_en = 1'b1; ccff_head = 1'b1; cfg_done = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; ccff_en = 1'b0; cfg_done = 1'b0;
    chk("midrst_state", cfg_state, 2'd0);
    chk("midrst_tail", ccff_tail, 1'b0);
    tail_seen = 1'b0;
    for (int i = 0; i < CFG_BITS - 1; i++) begin
      shift_bit(img[CFG_BITS-1-i], 1'b0);
      tail_seen = tail_seen | ccff_tail;
    end
    chk("midrst_cfg_cleared", tail_seen, 1'b0);
    shift_bit(img[0], 1'b1);
    chk("shift_beats_done", cfg_state, 2'd1);
    idle_cycle(1'b1);
    chk("reload_active", cfg_active, 1'b1);
    clb_I = '0;
    clb_I[3:0] = 4'hF; #1;
    chk("reload_and_F", clb_O, 10'h001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
